// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
//
// Pipeline hazard controller for a five-stage in-order core. It detects
// load-use hazards between ID/EX and IF/ID, and squashes wrong-path fetches
// after a taken branch (two-cycle penalty). It also freezes the front of the
// pipeline while a data-memory access is outstanding.
//
// The controller is a small FSM (RUN / MEM_WAIT / FLUSH). It has one extra
// bit, flush_pending, which remembers a taken branch that coincided with a
// memory stall, so the second wrong-path fetch is squashed once memory is
// ready. The outputs are combinational from the current state and the
// inputs, so the pipeline sees the response in the same cycle.
//
// Optional feature (macro HAZARD_STATS_EN): a saturating 16-bit counter of
// cycles in which the PC was held. When the macro is undefined, the port and
// the counter are absent.
//
// Ports
//   clk            pipeline clock, rising-edge active
//   rst_n          asynchronous active-low reset
//   PR2_MEM_read   ID/EX instruction is a load
//   PR2_rd         ID/EX destination register
//   PR1_rs/PR1_rt  IF/ID source registers
//   PR1_uses_rt    IF/ID instruction reads rt
//   branch_taken   branch resolved taken in EX this cycle
//   mem_req        EX/MEM instruction accesses data memory
//   mem_ready      data memory completes the access this cycle
//   PC_write_en, PR1_write_en, PR3_write_en   stage advance enables
//   PR1_flush, PR2_flush                      bubble into IF/ID, ID/EX
//   PR4_bubble     bubble into MEM/WB (register write suppressed)
//   stall_count    held-PC cycle counter (HAZARD_STATS_EN only)
// ---------------------------------------------------------------------------
module hazard_control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       PR2_MEM_read,
    input  logic [2:0] PR2_rd,
    input  logic [2:0] PR1_rs,
    input  logic [2:0] PR1_rt,
    input  logic       PR1_uses_rt,
    input  logic       branch_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       PC_write_en,
    output logic       PR1_write_en,
    output logic       PR3_write_en,
    output logic       PR1_flush,
    output logic       PR2_flush,
    output logic       PR4_bubble
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t state, state_next;
    logic   flush_pending, flush_pending_next;
    logic   load_use, mem_stall;

    // Register 0 is hardwired to zero, so a load into r0 never creates a hazard.
    assign load_use  = PR2_MEM_read && (PR2_rd != 3'd0) &&
                       ((PR2_rd == PR1_rs) || (PR1_uses_rt && (PR2_rd == PR1_rt)));
    assign mem_stall = mem_req && !mem_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned;
        // without that, synthesis would infer a latch.
        state_next         = state;
        flush_pending_next = flush_pending;
        PC_write_en        = 1'b1;
        PR1_write_en       = 1'b1;
        PR3_write_en       = 1'b1;
        PR1_flush          = 1'b0;
        PR2_flush          = 1'b0;
        PR4_bubble         = 1'b0;

        case (state)
            RUN: begin
                if (mem_stall) begin
                    PC_write_en        = 1'b0;
                    PR1_write_en       = 1'b0;
                    PR3_write_en       = 1'b0;
                    PR4_bubble         = 1'b1;
                    state_next         = MEM_WAIT;
                    // A branch that resolves under a memory stall still owes
                    // one wrong-path squash after the stall clears.
                    flush_pending_next = branch_taken;
                end else if (branch_taken) begin
                    PR1_flush  = 1'b1;
                    PR2_flush  = 1'b1;
                    state_next = FLUSH;
                end else if (load_use) begin
                    PC_write_en  = 1'b0;
                    PR1_write_en = 1'b0;
                    PR2_flush    = 1'b1;
                end
            end

            MEM_WAIT: begin
                if (!mem_ready) begin
                    PC_write_en  = 1'b0;
                    PR1_write_en = 1'b0;
                    PR3_write_en = 1'b0;
                    PR4_bubble   = 1'b1;
                end else begin
                    state_next         = flush_pending ? FLUSH : RUN;
                    flush_pending_next = 1'b0;
                end
            end

            FLUSH: begin
                PR1_flush  = 1'b1;
                state_next = RUN;
                if (mem_stall) begin
                    PC_write_en        = 1'b0;
                    PR1_write_en       = 1'b0;
                    PR3_write_en       = 1'b0;
                    PR4_bubble         = 1'b1;
                    state_next         = MEM_WAIT;
                    flush_pending_next = 1'b0;
                end
            end

            default: begin
                state_next         = RUN;
                flush_pending_next = 1'b0;
            end
        endcase

        // While reset is held, the pipeline is frozen and every stage is
        // bubbled. This does not wait for a clock edge.
        if (!rst_n) begin
            PC_write_en  = 1'b0;
            PR1_write_en = 1'b0;
            PR3_write_en = 1'b0;
            PR1_flush    = 1'b1;
            PR2_flush    = 1'b1;
            PR4_bubble   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so all registers
    // update together from values taken before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            flush_pending <= 1'b0;
        end else begin
            state         <= state_next;
            flush_pending <= flush_pending_next;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= 16'd0;
        end else if (!PC_write_en && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_control_unit
//
// Stimulus drives directed scenarios and then random traffic. For each cycle
// it computes the expected response from a reference model of the hazard
// rules and queues it. A monitor takes each expectation off the queue on the
// falling edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_hazard_control_unit;

    typedef struct packed {
        logic        pc_en;
        logic        pr1_en;
        logic        pr3_en;
        logic        f1;
        logic        f2;
        logic        bub;
        logic [15:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       PR2_MEM_read = 1'b0;
    logic [2:0] PR2_rd = 3'd0;
    logic [2:0] PR1_rs = 3'd0;
    logic [2:0] PR1_rt = 3'd0;
    logic       PR1_uses_rt = 1'b0;
    logic       branch_taken = 1'b0;
    logic       mem_req = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PC_write_en, PR1_write_en, PR3_write_en;
    logic       PR1_flush, PR2_flush, PR4_bubble;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count;
`endif

    hazard_control_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PR2_MEM_read (PR2_MEM_read),
        .PR2_rd       (PR2_rd),
        .PR1_rs       (PR1_rs),
        .PR1_rt       (PR1_rt),
        .PR1_uses_rt  (PR1_uses_rt),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .PC_write_en  (PC_write_en),
        .PR1_write_en (PR1_write_en),
        .PR3_write_en (PR3_write_en),
        .PR1_flush    (PR1_flush),
        .PR2_flush    (PR2_flush),
        .PR4_bubble   (PR4_bubble)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model, described in pipeline terms:
    //   mem_busy      - a data access is outstanding, so the front end is frozen
    //   squash_owed   - fetches on the wrong path still to be discarded
    //                   after a taken branch (the first squash happens
    //                   in the resolving cycle itself)
    //   branch_parked - a taken branch arrived during a memory freeze, and
    //                   its one remaining squash follows the freeze
    //   held_cycles   - number of cycles in which the PC did not advance
    // ------------------------------------------------------------------
    bit          mem_busy = 0;
    int          squash_owed = 0;
    bit          branch_parked = 0;
    int unsigned held_cycles = 0;

    function automatic exp_t model_step(input bit rst, input bit rd_mem, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt,
                                        input bit uses_rt, input bit bt,
                                        input bit req, input bit rdy);
        exp_t e;
        bit   stall_now, hazard, frozen;
        e = '{pc_en: 1'b1, pr1_en: 1'b1, pr3_en: 1'b1, f1: 1'b0, f2: 1'b0, bub: 1'b0,
              cnt: held_cycles[15:0]};
        stall_now = req && !rdy;
        hazard    = rd_mem && rd != 0 && (rd == rs || (uses_rt && rd == rt));
        frozen    = 0;
        if (!rst) begin
            e = '{pc_en: 1'b0, pr1_en: 1'b0, pr3_en: 1'b0, f1: 1'b1, f2: 1'b1, bub: 1'b1,
                  cnt: 16'd0};
            mem_busy = 0; squash_owed = 0; branch_parked = 0; held_cycles = 0;
            return e;
        end
        if (mem_busy) begin
            if (!rdy) frozen = 1;
            else begin
                mem_busy      = 0;
                squash_owed   = branch_parked ? 1 : 0;
                branch_parked = 0;
            end
        end else if (squash_owed > 0) begin
            e.f1        = 1'b1;
            squash_owed = squash_owed - 1;
            if (stall_now) begin
                frozen = 1; mem_busy = 1; branch_parked = 0;
            end
        end else if (stall_now) begin
            frozen = 1; mem_busy = 1; branch_parked = bt;
        end else if (bt) begin
            e.f1 = 1'b1; e.f2 = 1'b1; squash_owed = 1;
        end else if (hazard) begin
            e.pc_en = 1'b0; e.pr1_en = 1'b0; e.f2 = 1'b1;
        end
        if (frozen) begin
            e.pc_en = 1'b0; e.pr1_en = 1'b0; e.pr3_en = 1'b0; e.bub = 1'b1;
        end
        if (!e.pc_en && held_cycles < 32'hFFFF) held_cycles++;
        return e;
    endfunction

    // One cycle: drive just after the rising edge, queue the expectation.
    task automatic step(input bit rst, input bit rd_mem, input logic [2:0] rd,
                        input logic [2:0] rs, input logic [2:0] rt, input bit uses_rt,
                        input bit bt, input bit req, input bit rdy);
        @(posedge clk);
        #1;
        rst_n = rst; PR2_MEM_read = rd_mem; PR2_rd = rd; PR1_rs = rs; PR1_rt = rt;
        PR1_uses_rt = uses_rt; branch_taken = bt; mem_req = req; mem_ready = rdy;
        sb_q.push_back(model_step(rst, rd_mem, rd, rs, rt, uses_rt, bt, req, rdy));
    endtask

    task automatic idle();
        step(1, 0, 3'd0, 3'd1, 3'd2, 0, 0, 0, 0);
    endtask

    // Monitor: compare whatever expectation is due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("PC_write_en",  {15'd0, PC_write_en},  {15'd0, e.pc_en});
                check("PR1_write_en", {15'd0, PR1_write_en}, {15'd0, e.pr1_en});
                check("PR3_write_en", {15'd0, PR3_write_en}, {15'd0, e.pr3_en});
                check("PR1_flush",    {15'd0, PR1_flush},    {15'd0, e.f1});
                check("PR2_flush",    {15'd0, PR2_flush},    {15'd0, e.f2});
                check("PR4_bubble",   {15'd0, PR4_bubble},   {15'd0, e.bub});
`ifdef HAZARD_STATS_EN
                check("stall_count",  stall_count,           e.cnt);
`endif
            end
        end
    end

    initial begin
        int budget;
        // Reset state
        step(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0);
        step(0, 1, 3'd3, 3'd3, 3'd0, 0, 1, 1, 0);
        idle();

        // Load-use on rs, on rt, rt not used, and r0
        step(1, 1, 3'd3, 3'd3, 3'd0, 0, 0, 0, 0);
        step(1, 1, 3'd5, 3'd1, 3'd5, 1, 0, 0, 0);
        step(1, 1, 3'd5, 3'd1, 3'd5, 0, 0, 0, 0);
        step(1, 1, 3'd0, 3'd0, 3'd0, 1, 0, 0, 0);
        idle();

        // Taken branch: two squash cycles, then defaults
        step(1, 0, 3'd0, 3'd1, 3'd2, 0, 1, 0, 0);
        idle();
        idle();

        // Memory stall for 3 cycles, then the ready cycle
        repeat (3) step(1, 0, 3'd0, 3'd1, 3'd2, 0, 0, 1, 0);
        step(1, 0, 3'd0, 3'd1, 3'd2, 0, 0, 1, 1);
        idle();

        // Branch together with a memory stall; ready after 2 cycles
        step(1, 0, 3'd0, 3'd1, 3'd2, 0, 1, 1, 0);
        step(1, 1, 3'd4, 3'd4, 3'd0, 0, 1, 1, 0);
        step(1, 0, 3'd0, 3'd1, 3'd2, 0, 0, 1, 1);
        idle();
        idle();

        // Branch followed by a stall in the second squash cycle
        step(1, 0, 3'd0, 3'd1, 3'd2, 0, 1, 0, 0);
        step(1, 0, 3'd0, 3'd1, 3'd2, 0, 1, 1, 0);
        step(1, 0, 3'd0, 3'd1, 3'd2, 0, 0, 1, 1);
        idle();

        // Reset in the middle of a memory stall
        step(1, 0, 3'd0, 3'd1, 3'd2, 0, 1, 1, 0);
        step(1, 0, 3'd0, 3'd1, 3'd2, 0, 0, 1, 0);
        step(0, 0, 3'd0, 3'd1, 3'd2, 0, 0, 1, 0);
        step(1, 0, 3'd0, 3'd1, 3'd2, 0, 0, 0, 0);
        idle();

        // Random traffic, with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
        end

        budget = 20;
        while (sb_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
